// File: rtl/mux_scan_controller_if.sv
// Handshake and mux-facing signals of the mux scan controller.
//   start    : scan request, sampled at the rising edge
//   cont     : continuous mode, a new scan starts as soon as one completes
//   mux_in   : single-bit output of the 4:1 mux being scanned
//   sel      : select driven to the 4:1 mux
//   busy     : high while a scan is in progress
//   done     : one-cycle pulse marking a snapshot update
//   snapshot : bit k = mux_in captured while sel == k
// master = controlling logic / mux side, slave = the scan controller.
interface mux_scan_controller_if;
   logic       start;
   logic       cont;
   logic       mux_in;
   logic [1:0] sel;
   logic       busy;
   logic       done;
   logic [3:0] snapshot;

   modport master (
      output start, cont, mux_in,
      input  sel, busy, done, snapshot
   );

   modport slave (
      input  start, cont, mux_in,
      output sel, busy, done, snapshot
   );
endinterface

// File: rtl/mux_scan_controller.sv
// Sequential scanner around a 4:1 single-bit mux. Steps sel through channels
// 0..3, holds each channel for DWELL cycles, samples mux_in at the end of each
// dwell window and publishes a 4-bit snapshot with a one-cycle done pulse.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high reset
//   bus   : slave modport of mux_scan_controller_if (start/cont/mux_in in,
//           sel/busy/done/snapshot out, all outputs registered)
// Parameters:
//   DWELL : cycles each select value is held, legal range 1..255
//   CNT_W : dwell counter width, 2**CNT_W must exceed DWELL
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | sel parked at 0, waiting for start
// SCAN  | stepping sel 0..3, sampling mux_in at the end of each dwell
module mux_scan_controller #(
   parameter int DWELL = 1,
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   mux_scan_controller_if.slave  bus
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   state_t           state, state_n;
   logic [1:0]       sel, sel_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       shadow, shadow_n;
   logic [3:0]       snap, snap_n;
   logic             done_q, done_n;
   logic             busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         sel    <= 2'd0;
         cnt    <= '0;
         shadow <= 3'd0;
         snap   <= 4'd0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_n;
         sel    <= sel_n;
         cnt    <= cnt_n;
         shadow <= shadow_n;
         snap   <= snap_n;
         done_q <= done_n;
         // busy is registered from the next state so it tracks state exactly
         busy_q <= (state_n == SCAN);
      end
   end

   always_comb begin
      state_n  = state;
      sel_n    = sel;
      cnt_n    = cnt;
      shadow_n = shadow;
      snap_n   = snap;
      done_n   = 1'b0;

      unique case (state)
         IDLE: begin
            sel_n = 2'd0;
            cnt_n = '0;
            if (bus.start) begin
               state_n = SCAN;
            end
         end

         SCAN: begin
            if (cnt != CNT_LAST) begin
               cnt_n = cnt + CNT_W'(1);
            end else begin
               cnt_n = '0;
               unique case (sel)
                  2'd0: begin shadow_n[0] = bus.mux_in; sel_n = 2'd1; end
                  2'd1: begin shadow_n[1] = bus.mux_in; sel_n = 2'd2; end
                  2'd2: begin shadow_n[2] = bus.mux_in; sel_n = 2'd3; end
                  default: begin
                     // channel 3 goes straight into the snapshot; no shadow needed
                     snap_n  = {bus.mux_in, shadow};
                     done_n  = 1'b1;
                     sel_n   = 2'd0;
                     state_n = bus.cont ? SCAN : IDLE;
                  end
               endcase
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.sel      = sel;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.snapshot = snap;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller: one instance with DWELL=1 and one
// with DWELL=3. A scoreboard queue per instance holds the snapshot expected
// for each scan that should complete; every done pulse pops and compares.
module tb_mux_scan_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] a1, a3;

   mux_scan_controller_if if1 ();
   mux_scan_controller_if if3 ();

   assign if1.mux_in = a1[if1.sel];
   assign if3.mux_in = a3[if3.sel];

   mux_scan_controller #(.DWELL(1), .CNT_W(8)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1.slave)
   );

   mux_scan_controller #(.DWELL(3), .CNT_W(8)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (if3.slave)
   );

   int checks = 0;
   int errors = 0;
   int done_cnt1 = 0;
   int done_cnt3 = 0;
   logic [3:0] q1[$];
   logic [3:0] q3[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // scoreboard: every done pulse must match the oldest expected snapshot
   always @(negedge clk) begin
      if (if1.done === 1'b1) begin
         logic [3:0] e;
         done_cnt1++;
         checks++;
         assert (q1.size() != 0) else begin
            errors++;
            $error("FAIL sb1_unexpected_done observed=%b expected=no_done", if1.snapshot);
         end
         if (q1.size() != 0) begin
            e = q1.pop_front();
            checks++;
            assert (if1.snapshot === e) else begin
               errors++;
               $error("FAIL sb1_snapshot observed=%b expected=%b", if1.snapshot, e);
            end
         end
      end
      if (if3.done === 1'b1) begin
         logic [3:0] e;
         done_cnt3++;
         checks++;
         assert (q3.size() != 0) else begin
            errors++;
            $error("FAIL sb3_unexpected_done observed=%b expected=no_done", if3.snapshot);
         end
         if (q3.size() != 0) begin
            e = q3.pop_front();
            checks++;
            assert (if3.snapshot === e) else begin
               errors++;
               $error("FAIL sb3_snapshot observed=%b expected=%b", if3.snapshot, e);
            end
         end
      end
   end

   initial begin
      int d0;
      logic [3:0] pats [3];
      pats[0] = 4'b0011;
      pats[1] = 4'b1100;
      pats[2] = 4'b0101;

      reset = 1'b1;
      if1.start = 1'b0; if1.cont = 1'b0;
      if3.start = 1'b0; if3.cont = 1'b0;
      a1 = 4'b0000; a3 = 4'b0000;

      // reset then idle
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("idle1", 32'({if1.sel, if1.busy, if1.done, if1.snapshot}), 32'h0);
         chk("idle3", 32'({if3.sel, if3.busy, if3.done, if3.snapshot}), 32'h0);
      end

      // single scan, DWELL=1
      a1 = 4'b1010;
      if1.start = 1'b1;
      q1.push_back(4'b1010);
      tick(1);
      if1.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("scan1_busy_sel_done", 32'({if1.busy, if1.sel, if1.done}), 32'({1'b1, 2'(k), 1'b0}));
         tick(1);
      end
      chk("scan1_final", 32'({if1.busy, if1.sel, if1.done, if1.snapshot}), 32'({1'b0, 2'd0, 1'b1, 4'b1010}));
      tick(1);
      chk("scan1_done_clear", 32'({if1.busy, if1.done}), 32'h0);

      // DWELL=3 with start pulses ignored mid-scan
      a3 = 4'b0110;
      d0 = done_cnt3;
      if3.start = 1'b1;
      q3.push_back(4'b0110);
      tick(1);
      if3.start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         chk("scan3_sel", 32'({if3.busy, if3.sel, if3.done}), 32'({1'b1, 2'((i - 1) / 3), 1'b0}));
         if3.start = (i == 5 || i == 9);
         tick(1);
      end
      if3.start = 1'b0;
      chk("scan3_final", 32'({if3.busy, if3.done, if3.snapshot}), 32'({1'b0, 1'b1, 4'b0110}));
      tick(6);
      chk("scan3_one_done", 32'(done_cnt3 - d0), 32'd1);
      chk("scan3_idle", 32'({if3.busy, if3.done}), 32'h0);

      // continuous mode, DWELL=1
      a1 = 4'b0001;
      if1.start = 1'b1;
      if1.cont = 1'b1;
      q1.push_back(4'b0001);
      tick(1);
      if1.start = 1'b0;
      tick(3);
      chk("cont_no_done_early", 32'(if1.done), 32'h0);
      tick(1);
      chk("cont_done1", 32'({if1.busy, if1.done, if1.snapshot}), 32'({1'b1, 1'b1, 4'b0001}));
      a1 = 4'b1000;
      q1.push_back(4'b1000);
      if1.cont = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("cont_mid", 32'({if1.busy, if1.done}), 32'({1'b1, 1'b0}));
      end
      tick(1);
      chk("cont_done2", 32'({if1.busy, if1.done, if1.snapshot}), 32'({1'b0, 1'b1, 4'b1000}));
      tick(1);
      chk("cont_stopped", 32'({if1.busy, if1.done}), 32'h0);

      // reset mid-scan after a 1111 snapshot
      a1 = 4'b1111;
      if1.start = 1'b1;
      q1.push_back(4'b1111);
      tick(1);
      if1.start = 1'b0;
      tick(4);
      chk("pre_reset_snap", 32'(if1.snapshot), 32'(4'b1111));
      tick(1);
      d0 = done_cnt1;
      if1.start = 1'b1;
      tick(1);
      if1.start = 1'b0;
      tick(2);
      chk("pre_reset_sel", 32'(if1.sel), 32'd2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("post_reset", 32'({if1.sel, if1.busy, if1.done, if1.snapshot}), 32'h0);
      tick(6);
      chk("post_reset_no_done", 32'(done_cnt1 - d0), 32'd0);
      chk("post_reset_idle", 32'({if1.busy, if1.snapshot}), 32'h0);

      // immediate restart: start held, cont=0
      a1 = pats[0];
      q1.push_back(pats[0]);
      if1.start = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick(4);
         chk("restart_pre_done", 32'(if1.done), 32'h0);
         tick(1);
         chk("restart_done", 32'({if1.busy, if1.done, if1.snapshot}), 32'({1'b0, 1'b1, pats[j]}));
         if (j < 2) begin
            a1 = pats[j + 1];
            q1.push_back(pats[j + 1]);
         end
      end
      if1.start = 1'b0;
      tick(3);
      chk("restart_idle", 32'({if1.busy, if1.done}), 32'h0);

      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q3_drained", 32'(q3.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
- Sequential scanner that sits around the 4:1 single-bit multiplexer.
- Upstream: drives the mux's 2-bit select through channels 0..3.
- Downstream: samples the mux's 1-bit output on each channel and assembles a 4-bit snapshot.
- Start/busy/done handshake to the controlling logic; optional continuous-scan mode.

Parameters:
- DWELL, 1, cycles each select value is held before the mux output is sampled; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a scan; sampled at rising edge
- cont  input  1  continuous mode: auto-restart a new scan when the current one completes
- mux_in  input  1  single-bit output of the 4:1 mux being scanned
- sel  output  2  select driven to the 4:1 mux
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse marking snapshot update
- snapshot  output  4  bit k = value of mux_in captured while sel==k

Behaviour:
- Reset (synchronous, active-high): state=IDLE, sel=0, cnt=0, shadow=0, snapshot=0, done=0, busy=0. Reset overrides all other inputs. Reset mid-scan aborts the scan: no done, snapshot keeps 0.
- All outputs are registered. busy = (state==SCAN).
- FSM states: IDLE, SCAN.
- IDLE: sel=0. If start is high at an edge: go to SCAN, set sel=0 and cnt=0.
- SCAN, at each edge:
  - If cnt != DWELL-1: cnt <= cnt+1; sel holds.
  - If cnt == DWELL-1 (sample edge): shadow[sel] <= mux_in and cnt <= 0.
    - If sel<3: sel <= sel+1.
    - If sel==3 (final edge): snapshot <= {mux_in, shadow[2:0]}, done <= 1, sel <= 0. Next state is SCAN if cont==1, else IDLE.
- start while busy is ignored and is not queued.
- done is high for exactly one cycle after each final edge; it is cleared at the next edge unless that edge is itself a final edge. With DWELL=1 and cont=1, done is high one cycle in every 4.
- Latency: start accepted at edge E0 → samples at edges E0+DWELL·(k+1), k=0..3 → snapshot and done valid in the cycle after edge E0+4·DWELL.
- sel is stable for DWELL cycles per channel. mux_in is sampled at the end of the dwell window, so the combinational mux path has at least one full cycle to settle.
- In IDLE after a done cycle, start is accepted immediately. Back-to-back scans are therefore separated by 1 idle cycle; with cont=1 there are 0 idle cycles.
- cont is sampled only at the final edge. Deasserting cont mid-scan lets the current scan finish, then returns to IDLE.
- snapshot holds its value until the next final edge or reset. Partial scans never modify snapshot.
- Counter wrap: cnt never exceeds DWELL-1. sel wraps 3→0 only at the final edge.

Test Plan:
- Reset, then idle: reset=1 for 2 cycles, release → sel=0, busy=0, done=0, snapshot=4'b0000. These hold for 10 cycles with start=0.
- Single scan, DWELL=1, mux a=4'b1010: pulse start 1 cycle → busy high for 4 cycles, sel=0,1,2,3. One-cycle done pulse after the 4th sample edge, snapshot=4'b1010, then sel=0, busy=0.
- DWELL=3, a=4'b0110: start → each sel value held 3 cycles; done 12 cycles after the start edge; snapshot=4'b0110. start pulses inside the scan are ignored, giving exactly one done.
- Continuous mode, DWELL=1, cont=1, a changes 4'b0001 → 4'b1000 between scans: done pulses every 4 cycles with snapshots 4'b0001 then 4'b1000. Drop cont → current scan completes, then busy=0.
- Reset mid-scan: assert reset when sel=2 after a prior snapshot of 4'b1111 → next cycle sel=0, busy=0, snapshot=4'b0000, and no done pulse occurs.
- Immediate restart: start held high continuously, cont=0, DWELL=1 → done pulses every 5 cycles (4 SCAN cycles + 1 IDLE cycle), with snapshot tracking a on each pulse.
